clock_div_ctrl: RTL and testbench
=================================

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of divisor and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, meaning divisor loaded at reset.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level, request to begin generating divided clock.
REQ-006 SHALL have port stop  input  1  level, request for clean stop.
REQ-007 SHALL have port div_load  input  1  one-cycle request to change divisor.
REQ-008 SHALL have port div_value  input  WIDTH  requested divisor, sampled when div_load=1.
REQ-009 SHALL have port div_ack  output  1  one-cycle pulse confirming divisor capture.
REQ-010 SHALL have port en_tick  output  1  one-cycle clock-enable pulse every N cycles.
REQ-011 SHALL have port clk_out  output  1  divided clock, toggles on each en_tick, period 2N cycles.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STOPPING.

Function
REQ-014 SHALL register every output; no combinational path from any input to any output.
REQ-015 SHALL hold active divisor N; divisor value 0 or 1 SHALL be stored as 2 (minimum N=2).
REQ-016 IDLE: counter=0, clk_out=0, en_tick=0; start=1 and stop=0 at an edge -> RUN, counter restarts at 0.
REQ-017 RUN: counter increments each cycle, 0..N-1; on edge where counter=N-1, counter wraps to 0, en_tick=1 for one cycle, clk_out toggles.
REQ-018 First en_tick SHALL be high exactly N cycles after the edge that accepted start.
REQ-019 div_load=1 at an edge: div_value captured into pending register, div_ack=1 on the following cycle only.
REQ-020 In IDLE a captured divisor SHALL become N immediately; in RUN/STOPPING it SHALL become N at the next counter wrap, never mid-period.
REQ-021 A second div_load before the pending value is applied SHALL overwrite it; only the latest value applies; each load gets its own div_ack.
REQ-022 stop=1 in RUN -> STOPPING; STOPPING continues counting with same N.
REQ-023 STOPPING: at a wrap where clk_out=1 (falling toggle) -> IDLE with clk_out=0; at a wrap where clk_out=0, toggle to 1 and remain STOPPING.
REQ-024 clk_out SHALL never produce a high or low phase shorter than N cycles, including across stop and divisor change.
REQ-025 start and stop both 1 in IDLE: stop wins, remain IDLE; start while RUN/STOPPING ignored.
REQ-026 stop=1 in IDLE SHALL have no effect.
REQ-027 Counter SHALL not overflow: compare uses N-1 at full WIDTH, N=2^WIDTH-1 maximum.

Reset
REQ-028 reset=1 SHALL immediately, without clk, force state=IDLE, counter=0, N=DEFAULT_DIV, pending cleared, clk_out=0, en_tick=0, div_ack=0, busy=0.
REQ-029 reset asserted mid-RUN or mid-STOPPING SHALL abort the period; a pending divisor SHALL be discarded.
REQ-030 After reset release, block SHALL stay IDLE until start sampled high.

Verification
REQ-031 Reset, start=1 one cycle, N=4 -> en_tick every 4 cycles, first 4 cycles after start edge; clk_out period 8, 4 high/4 low.
REQ-032 RUN with N=4, div_load with div_value=6 at counter=1 -> div_ack next cycle; current period still ends at 4 cycles; subsequent en_tick spacing 6.
REQ-033 IDLE, div_load div_value=0, then start -> N=2, en_tick every 2 cycles, clk_out period 4.
REQ-034 RUN N=4, stop pulsed while clk_out=0 -> clk_out rises, stays high 4 cycles, falls, state=IDLE, busy=0; no further en_tick.
REQ-035 RUN N=5, reset pulsed asynchronously between clk edges -> outputs zero before next edge; later start uses N=4 (DEFAULT_DIV).
REQ-036 IDLE, start=1 and stop=1 same cycle -> remains IDLE, busy=0, no en_tick.

Source files
------------

// File: rtl/clock_div_ctrl.sv
// Programmable clock divider: emits a one-cycle enable every N cycles and a 50% duty
// divided clock, with glitch-free divisor changes and a clean stop on a low phase.
module clock_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ack,
  output logic             en_tick,
  output logic             clk_out,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    STOPPING = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MIN_N     = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEFAULT_N = (DEFAULT_DIV < 2) ? MIN_N : WIDTH'(DEFAULT_DIV);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             clk_out_reg, clk_out_next;
  logic             en_tick_reg, en_tick_next;
  logic             div_ack_reg, div_ack_next;
  logic             busy_reg, busy_next;
  logic             wrap;
  logic [WIDTH-1:0] load_val;

  // Divisors below 2 cannot produce a toggling output, so they are raised to 2.
  assign load_val = (div_value < MIN_N) ? MIN_N : div_value;
  assign wrap     = (count_reg == (n_reg - WIDTH'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      n_reg          <= DEFAULT_N;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      clk_out_reg    <= 1'b0;
      en_tick_reg    <= 1'b0;
      div_ack_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      n_reg          <= n_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      clk_out_reg    <= clk_out_next;
      en_tick_reg    <= en_tick_next;
      div_ack_reg    <= div_ack_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    n_next          = n_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    clk_out_next    = clk_out_reg;
    en_tick_next    = 1'b0;
    div_ack_next    = div_load;

    case (state_reg)
      IDLE: begin
        count_next   = '0;
        clk_out_next = 1'b0;
        // A load captured on the final stopping edge lands here and is applied at once.
        if (pend_valid_reg) begin
          n_next          = pend_reg;
          pend_valid_next = 1'b0;
        end
        if (div_load) begin
          n_next = load_val;
        end
        if (start && !stop) begin
          state_next = RUN;
        end
      end

      RUN, STOPPING: begin
        if (wrap) begin
          count_next   = '0;
          en_tick_next = 1'b1;
          if (pend_valid_reg) begin
            n_next          = pend_reg;
            pend_valid_next = 1'b0;
          end
          if ((state_reg == STOPPING) && clk_out_reg) begin
            clk_out_next = 1'b0;
            state_next   = IDLE;
          end else begin
            clk_out_next = ~clk_out_reg;
          end
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
        if ((state_reg == RUN) && stop) begin
          state_next = STOPPING;
        end
        // A load on a wrap edge is held for the following wrap, never mid-period.
        if (div_load) begin
          pend_next       = load_val;
          pend_valid_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign state   = state_reg;
  assign clk_out = clk_out_reg;
  assign en_tick = en_tick_reg;
  assign div_ack = div_ack_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed self-checking bench for clock_div_ctrl; inputs change and outputs are
// sampled on the falling clock edge, so edge k is the k-th rising edge after start.
module tb_clock_div_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       div_load = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic       div_ack, en_tick, clk_out, busy;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .div_load(div_load), .div_value(div_value),
    .div_ack(div_ack), .en_tick(en_tick), .clk_out(clk_out),
    .busy(busy), .state(state)
  );

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0; div_value = 8'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drives start for one edge; returns after edge 0 (the accepting edge).
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({state, busy, clk_out, en_tick, div_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got state=%b busy=%b clk_out=%b en_tick=%b div_ack=%b, want all 0",
               state, busy, clk_out, en_tick, div_ack);
    end
    do_reset();
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (state !== 2'b00 || busy !== 1'b0 || en_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stay_idle: got state=%b busy=%b en_tick=%b, want 00/0/0", state, busy, en_tick);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    pulse_start();
    n_checks++;
    if (state !== 2'b01 || busy !== 1'b1 || en_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_enter_run: got state=%b busy=%b en_tick=%b, want 01/1/0", state, busy, en_tick);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (en_tick !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL basic_en_tick k=%0d: got %b want %b", k, en_tick, (k % 4 == 0));
      end
      n_checks++;
      if (clk_out !== ((k / 4) % 2 == 1)) begin
        n_fail++;
        $display("FAIL basic_clk_out k=%0d: got %b want %b", k, clk_out, ((k / 4) % 2 == 1));
      end
    end
    $display("test_basic done");
  endtask

  task automatic test_div_change();
    do_reset();
    pulse_start();
    @(negedge clk);                       // edge 1, counter=1
    div_load = 1'b1; div_value = 8'd6;
    @(negedge clk);                       // edge 2 captured the load
    div_load = 1'b0;
    n_checks++;
    if (div_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL divchg_ack: got %b want 1", div_ack);
    end
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (div_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL divchg_ack_once k=%0d: got %b want 0", k, div_ack);
      end
      n_checks++;
      if (en_tick !== (k == 4 || k == 10 || k == 16)) begin
        n_fail++;
        $display("FAIL divchg_en_tick k=%0d: got %b want %b", k, en_tick, (k == 4 || k == 10 || k == 16));
      end
    end
    $display("test_div_change done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    @(negedge clk);                       // edge 1
    div_load = 1'b1; div_value = 8'd3;
    @(negedge clk);                       // edge 2
    div_value = 8'd5;
    n_checks++;
    if (div_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ack1: got %b want 1", div_ack);
    end
    @(negedge clk);                       // edge 3
    div_load = 1'b0;
    n_checks++;
    if (div_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ack2: got %b want 1", div_ack);
    end
    for (int k = 4; k <= 15; k++) begin
      @(negedge clk);
      n_checks++;
      if (en_tick !== (k == 4 || k == 9 || k == 14)) begin
        n_fail++;
        $display("FAIL b2b_en_tick k=%0d: got %b want %b", k, en_tick, (k == 4 || k == 9 || k == 14));
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_div_zero();
    do_reset();
    div_load = 1'b1; div_value = 8'd0;
    @(negedge clk);
    div_load = 1'b0;
    n_checks++;
    if (div_ack !== 1'b1 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL divzero_ack: got ack=%b state=%b want 1/00", div_ack, state);
    end
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (en_tick !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL divzero_en_tick k=%0d: got %b want %b", k, en_tick, (k % 2 == 0));
      end
      n_checks++;
      if (clk_out !== ((k / 2) % 2 == 1)) begin
        n_fail++;
        $display("FAIL divzero_clk_out k=%0d: got %b want %b", k, clk_out, ((k / 2) % 2 == 1));
      end
    end
    $display("test_div_zero done");
  endtask

  task automatic test_stop();
    do_reset();
    pulse_start();
    @(negedge clk);                       // edge 1, clk_out low
    stop = 1'b1;
    @(negedge clk);                       // edge 2 accepted stop
    stop = 1'b0;
    n_checks++;
    if (state !== 2'b10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_enter: got state=%b busy=%b want 10/1", state, busy);
    end
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (en_tick !== (k == 4 || k == 8)) begin
        n_fail++;
        $display("FAIL stop_en_tick k=%0d: got %b want %b", k, en_tick, (k == 4 || k == 8));
      end
      n_checks++;
      if (clk_out !== (k >= 4 && k < 8)) begin
        n_fail++;
        $display("FAIL stop_clk_out k=%0d: got %b want %b", k, clk_out, (k >= 4 && k < 8));
      end
      n_checks++;
      if (state !== ((k < 8) ? 2'b10 : 2'b00) || busy !== (k < 8)) begin
        n_fail++;
        $display("FAIL stop_state k=%0d: got state=%b busy=%b want %b/%b",
                 k, state, busy, ((k < 8) ? 2'b10 : 2'b00), (k < 8));
      end
    end
    $display("test_stop done");
  endtask

  task automatic test_async_reset();
    do_reset();
    div_load = 1'b1; div_value = 8'd5;
    @(negedge clk);
    div_load = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);            // edge 5: first wrap with N=5
    n_checks++;
    if (clk_out !== 1'b1 || en_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got clk_out=%b en_tick=%b want 1/1", clk_out, en_tick);
    end
    div_load = 1'b1; div_value = 8'd9;
    @(negedge clk);                       // edge 6 leaves 9 pending
    div_load = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({state, busy, clk_out, en_tick, div_ack} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_async: got state=%b busy=%b clk_out=%b en_tick=%b div_ack=%b want all 0",
               state, busy, clk_out, en_tick, div_ack);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (en_tick !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL areset_default_n k=%0d: got %b want %b", k, en_tick, (k % 4 == 0));
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_start_stop_same();
    do_reset();
    start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 2'b00 || busy !== 1'b0 || en_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL startstop_idle k=%0d: got state=%b busy=%b en_tick=%b want 00/0/0", k, state, busy, en_tick);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 2'b00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stop k=%0d: got state=%b busy=%b want 00/0", k, state, busy);
      end
    end
    stop = 1'b0;
    pulse_start();
    n_checks++;
    if (state !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL startstop_then_run: got state=%b busy=%b want 01/1", state, busy);
    end
    $display("test_start_stop_same done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change();
    test_back_to_back();
    test_div_zero();
    test_stop();
    test_async_reset();
    test_start_stop_same();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
